// File: rtl/mem_arb_pkg.sv
// Shared types and UART register map for the mmu port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;

  localparam logic [31:0] UART_STATUS = 32'h200;
  localparam logic [31:0] UART_TX     = 32'h201;
  localparam logic [31:0] UART_RX     = 32'h202;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-shot arbiter sharing the mmu port between fetch (I) and load/store (D).
// Build option MEM_ARB_RR_EN: round-robin on ties instead of fixed D priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic        clock,
  input  logic        RST,
  input  logic        iReq,
  input  logic [31:0] iAddr,
  output logic        iGnt,
  output logic        iValid,
  output logic [31:0] iRdata,
  input  logic        dReq,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  input  logic [3:0]  dByteena,
  input  logic        dWE,
  output logic        dGnt,
  output logic        dValid,
  output logic [31:0] dRdata,
  output logic [31:0] memAddr,
  output logic [31:0] memData,
  output logic [3:0]  memByteena,
  output logic        memWE,
  input  logic        memWait,
  input  logic [31:0] memQ
);

  localparam logic [2:0] LAT_M1 = 3'(RD_LATENCY - 1);

  arb_state_t  r_state, w_next;
  arb_owner_t  r_owner, w_pick;
  logic [31:0] r_addr, r_wdata, r_irdata, r_drdata;
  logic [3:0]  r_be;
  logic        r_we;
  logic [2:0]  r_cnt;
  logic        w_grant, w_done;

`ifdef MEM_ARB_RR_EN
  arb_owner_t r_last;

  // Tie goes to whoever did not own the port last; a lone requester always wins.
  always_comb begin
    w_pick = dReq ? OWN_D : OWN_I;
    if (iReq && dReq)
      w_pick = (r_last == OWN_I) ? OWN_D : OWN_I;
  end

  always_ff @(posedge clock or posedge RST) begin
    if (RST)          r_last <= OWN_I;
    else if (w_grant) r_last <= w_pick;
  end
`else
  assign w_pick = dReq ? OWN_D : OWN_I;
`endif

  assign w_grant = !RST && (r_state == ST_IDLE) && (iReq || dReq);
  assign w_done  = (r_state == ST_RESP) && (r_cnt == 3'd0);

  assign iGnt   = w_grant && (w_pick == OWN_I);
  assign dGnt   = w_grant && (w_pick == OWN_D);
  assign iValid = w_done && (r_owner == OWN_I);
  assign dValid = w_done && (r_owner == OWN_D);

  // Read data is presented with the valid pulse and held afterwards.
  assign iRdata = iValid ? memQ : r_irdata;
  assign dRdata = (dValid && !r_we) ? memQ : r_drdata;

  assign memAddr    = r_addr;
  assign memData    = r_wdata;
  assign memByteena = r_be;
  assign memWE      = (r_state == ST_ISSUE) && !memWait && r_we;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_grant)  w_next = ST_ISSUE;
      ST_ISSUE: if (!memWait) w_next = ST_RESP;
      ST_RESP:  if (w_done)   w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge RST) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_owner  <= OWN_I;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_we     <= 1'b0;
      r_cnt    <= '0;
      r_irdata <= '0;
      r_drdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_owner <= w_pick;
        if (w_pick == OWN_D) begin
          r_addr  <= dAddr;
          r_wdata <= dWdata;
          r_be    <= dByteena;
          r_we    <= dWE;
        end else begin
          r_addr  <= iAddr;
          r_wdata <= '0;
          r_be    <= '0;
          r_we    <= 1'b0;
        end
      end
      if (r_state == ST_ISSUE && !memWait)
        r_cnt <= LAT_M1;
      else if (r_state == ST_RESP && r_cnt != 3'd0)
        r_cnt <= r_cnt - 3'd1;
      if (iValid) r_irdata <= memQ;
      if (dValid && !r_we) r_drdata <= memQ;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: synchronous RAM + UART register model behind the arbiter.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clock = 1'b0, RST = 1'b1;
  logic        iReq = 0, dReq = 0, dWE = 0, memWait = 0;
  logic [31:0] iAddr = 0, dAddr = 0, dWdata = 0;
  logic [3:0]  dByteena = 0;
  logic        iGnt, iValid, dGnt, dValid, memWE;
  logic [31:0] iRdata, dRdata, memAddr, memData, memQ;
  logic [3:0]  memByteena;

  int nchk = 0, nerr = 0;
  int weCnt = 0, uartWE = 0, ivCnt = 0, dvCnt = 0;

  logic [31:0] mem [0:255] = '{default: 32'h0};
  logic        rxReady, txBusy;
  logic [31:0] memQ_r = 0;
  assign memQ = memQ_r;

  always #5 clock = ~clock;

  mem_port_arbiter #(.RD_LATENCY(1)) dut (
    .clock(clock), .RST(RST),
    .iReq(iReq), .iAddr(iAddr), .iGnt(iGnt), .iValid(iValid), .iRdata(iRdata),
    .dReq(dReq), .dAddr(dAddr), .dWdata(dWdata), .dByteena(dByteena), .dWE(dWE),
    .dGnt(dGnt), .dValid(dValid), .dRdata(dRdata),
    .memAddr(memAddr), .memData(memData), .memByteena(memByteena), .memWE(memWE),
    .memWait(memWait), .memQ(memQ)
  );

  // mmu model: RAM words at 0..0xFF, UART status/tx/rx at 0x200..0x202
  always @(posedge clock) begin
    if (RST) begin
      rxReady <= 1'b1;
      txBusy  <= 1'b0;
    end else begin
      if (memWE && memAddr == UART_TX) txBusy <= 1'b1;
      else if (memWE && memAddr < 32'h100)
        for (int b = 0; b < 4; b++)
          if (memByteena[b]) mem[memAddr[7:0]][b*8 +: 8] <= memData[b*8 +: 8];
      if (!memWE && memAddr == UART_RX) rxReady <= 1'b0;
    end
    if (memAddr == UART_STATUS)  memQ_r <= {30'b0, txBusy, rxReady};
    else if (memAddr == UART_RX) memQ_r <= 32'h5A;
    else                         memQ_r <= mem[memAddr[7:0]];
  end

  always @(posedge clock) begin
    if (memWE) weCnt <= weCnt + 1;
    if (memWE && memAddr == UART_TX) uartWE <= uartWE + 1;
    if (iValid) ivCnt <= ivCnt + 1;
    if (dValid) dvCnt <= dvCnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // One transaction; returns data, cycles from grant to valid and memWE pulses seen.
  task automatic txn(input bit isI, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output logic [31:0] rd, output int lat, output int nwe);
    int k, w0;
    @(negedge clock);
    w0 = weCnt;
    if (isI) begin iReq = 1; iAddr = addr; end
    else begin dReq = 1; dAddr = addr; dWE = we; dWdata = wdata; dByteena = be; end
    #1;
    k = 0;
    while (!(isI ? iGnt : dGnt) && k < 20) begin @(negedge clock); #1; k++; end
    chk1("gnt", isI ? iGnt : dGnt, 1'b1);
    @(posedge clock); #1;
    iReq = 0; dReq = 0;
    lat = 0; rd = 'x;
    while (lat < 20) begin
      @(negedge clock);
      lat++;
      if (isI ? iValid : dValid) begin rd = isI ? iRdata : dRdata; break; end
    end
    nwe = weCnt - w0;
  endtask

  task automatic tie(output bit gotD);
    @(negedge clock);
    iReq = 1; iAddr = 32'h0; dReq = 1; dAddr = 32'h80; dWE = 0;
    #1;
    gotD = dGnt;
    chk1("tie_onehot", iGnt ^ dGnt, 1'b1);
    @(posedge clock); #1;
    iReq = 0; dReq = 0;
    @(negedge clock);
    @(negedge clock);
    chk1("tie_valid", gotD ? dValid : iValid, 1'b1);
    chk("tie_data", gotD ? dRdata : iRdata, gotD ? 32'hCAFEF00D : 32'h13579BDF);
  endtask

  typedef struct {
    bit          isI;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] rd, lastD;
    int lat, nwe, k, v0, u0;
    bit gotD, expD;

    vecs[0]  = '{0, 1, 32'h40,  32'hDEADBEEF, 4'hF, 32'h0};
    vecs[1]  = '{0, 0, 32'h40,  32'h0,        4'h0, 32'hDEADBEEF};
    vecs[2]  = '{0, 1, 32'h00,  32'h13579BDF, 4'hF, 32'h0};
    vecs[3]  = '{1, 0, 32'h00,  32'h0,        4'h0, 32'h13579BDF};
    vecs[4]  = '{0, 1, 32'h10,  32'hAABBCCDD, 4'hF, 32'h0};
    vecs[5]  = '{0, 1, 32'h80,  32'hCAFEF00D, 4'hF, 32'h0};
    vecs[6]  = '{0, 1, 32'h40,  32'h0000A5A5, 4'hC, 32'h0};
    vecs[7]  = '{0, 0, 32'h40,  32'h0,        4'h0, 32'h0000BEEF};
    vecs[8]  = '{1, 0, 32'h80,  32'h0,        4'h0, 32'hCAFEF00D};
    vecs[9]  = '{0, 0, 32'h200, 32'h0,        4'h0, 32'h1};
    vecs[10] = '{0, 0, 32'h202, 32'h0,        4'h0, 32'h5A};
    vecs[11] = '{0, 0, 32'h200, 32'h0,        4'h0, 32'h0};
    vecs[12] = '{0, 1, 32'h201, 32'h41,       4'h1, 32'h0};
    vecs[13] = '{0, 0, 32'h200, 32'h0,        4'h0, 32'h2};

    repeat (2) @(negedge clock);
    iReq = 1; #1;
    chk1("rst_iGnt", iGnt, 1'b0);
    chk1("rst_dGnt", dGnt, 1'b0);
    chk1("rst_valid", iValid | dValid, 1'b0);
    chk1("rst_memWE", memWE, 1'b0);
    chk("rst_memAddr", memAddr, 32'h0);
    chk("rst_memData", memData, 32'h0);
    chk("rst_memBe", {28'b0, memByteena}, 32'h0);
    chk("rst_rdata", iRdata | dRdata, 32'h0);
    iReq = 0;
    @(negedge clock); RST = 0;

    lastD = 32'h0;
    for (int i = 0; i < 14; i++) begin
      v0 = dvCnt + ivCnt; u0 = uartWE;
      txn(vecs[i].isI, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, lat, nwe);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd2);
      chk($sformatf("v%0d_nwe", i), 32'(nwe), {31'b0, vecs[i].we});
      if (vecs[i].isI || !vecs[i].we) begin
        chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp);
        if (!vecs[i].isI) lastD = vecs[i].exp;
      end else
        chk($sformatf("v%0d_hold", i), rd, lastD);
      @(negedge clock);
      chk($sformatf("v%0d_pulses", i), 32'(dvCnt + ivCnt - v0), 32'd1);
      if (vecs[i].addr == UART_TX) chk("uart_we", 32'(uartWE - u0), 32'd1);
    end

    // Partial store stalled by memWait for three cycles
    @(negedge clock);
    dReq = 1; dAddr = 32'h10; dWE = 1; dWdata = 32'h11223344; dByteena = 4'b0011; memWait = 1;
    #1;
    chk1("ws_gnt", dGnt, 1'b1);
    k = weCnt;
    @(posedge clock); #1; dReq = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk1($sformatf("ws_noWE%0d", c), memWE, 1'b0);
      chk1($sformatf("ws_novld%0d", c), dValid, 1'b0);
    end
    chk("ws_addr", memAddr, 32'h10);
    chk("ws_be", {28'b0, memByteena}, 32'h3);
    memWait = 0; #1;
    chk1("ws_WE", memWE, 1'b1);
    @(negedge clock);
    chk1("ws_dValid", dValid, 1'b1);
    chk1("ws_WE_off", memWE, 1'b0);
    chk("ws_wecount", 32'(weCnt - k), 32'd1);
    txn(0, 0, 32'h10, 32'h0, 4'h0, rd, lat, nwe);
    chk("ws_readback", rd, 32'hAABB3344);

    // Tie from a fresh reset: D first, I granted three cycles later
    @(negedge clock); RST = 1;
    @(negedge clock); RST = 0;
    @(negedge clock);
    iReq = 1; iAddr = 32'h0; dReq = 1; dAddr = 32'h80; dWE = 0;
    #1;
    chk1("tie0_dGnt", dGnt, 1'b1);
    chk1("tie0_iGnt", iGnt, 1'b0);
    @(posedge clock); #1; dReq = 0;
    k = 0;
    while (!iGnt && k < 20) begin @(negedge clock); k++; end
    chk("tie0_igap", 32'(k), 32'd3);
    @(posedge clock); #1; iReq = 0;
    @(negedge clock);
    @(negedge clock);
    chk1("tie0_iValid", iValid, 1'b1);
    chk("tie0_iRdata", iRdata, 32'h13579BDF);

    // Last owner is I here, so round-robin alternates D,I,D,I; fixed priority always D
    for (int t = 0; t < 4; t++) begin
      tie(gotD);
`ifdef MEM_ARB_RR_EN
      expD = (t % 2 == 0);
`else
      expD = 1'b1;
`endif
      chk1($sformatf("tie%0d_owner", t + 1), gotD, expD);
    end

    // Reset during the fetch response aborts it
    @(negedge clock);
    iReq = 1; iAddr = 32'h80; #1;
    chk1("ra_gnt", iGnt, 1'b1);
    @(posedge clock); #1; iReq = 0;
    v0 = ivCnt;
    @(posedge clock); #1;
    RST = 1; #1;
    chk1("ra_iValid", iValid, 1'b0);
    chk("ra_memAddr", memAddr, 32'h0);
    chk("ra_iRdata", iRdata, 32'h0);
    @(negedge clock); RST = 0;
    repeat (2) @(negedge clock);
    chk("ra_nopulse", 32'(ivCnt - v0), 32'd0);
    txn(1, 0, 32'h0, 32'h0, 4'h0, rd, lat, nwe);
    chk("ra_refetch_lat", 32'(lat), 32'd2);
    chk("ra_refetch", rd, 32'h13579BDF);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
